// File: rtl/regfile_wb_queue_if.sv
// Writeback request, register-file write port and hazard-query bundle for
// regfile_wb_queue.
// Handshake: a source transfers on a rising edge where its valid and ready are
// both high; it holds valid, address and data stable until that edge. Ready
// never depends on valid.
interface regfile_wb_queue_if;
  logic        memValid;
  logic [4:0]  memA;
  logic [31:0] memD;
  logic        memReady;
  logic        aluValid;
  logic [4:0]  aluA;
  logic [31:0] aluD;
  logic        aluReady;
  logic [4:0]  wA;
  logic [31:0] wD;
  logic        wrEn;
  logic [4:0]  rA1;
  logic [4:0]  rA2;
  logic        pend1;
  logic        pend2;

  modport master (
    output memValid, memA, memD, aluValid, aluA, aluD, rA1, rA2,
    input  memReady, aluReady, wA, wD, wrEn, pend1, pend2
  );

  modport slave (
    input  memValid, memA, memD, aluValid, aluA, aluD, rA1, rA2,
    output memReady, aluReady, wA, wD, wrEn, pend1, pend2
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register-file write port. Accepts up to two
// writes per cycle (mem older than ALU), drains one per cycle in order, drops
// writes to r0, bypasses straight to the port when empty, and flags pending
// writes for two read addresses. dbg_count exposes the queue occupancy.
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_wb_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] dbg_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_LEFT = CW'(DEPTH - 1);

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          mem_keep;
  logic          alu_keep;
  logic          s0_v;
  logic          s1_v;
  logic [4:0]    s0_a;
  logic [4:0]    s1_a;
  logic [31:0]   s0_d;
  logic [31:0]   s1_d;
  logic          pop;
  logic          bypass;
  logic          e0_v;
  logic          e1_v;
  logic [4:0]    e0_a;
  logic [4:0]    e1_a;
  logic [31:0]   e0_d;
  logic [31:0]   e1_d;
  logic [1:0]    pushes;
  logic [DEPTH-1:0] live;

  // Readiness comes from registered occupancy only.
  assign bus.memReady = (count < FULL);
  assign bus.aluReady = (count < ONE_LEFT);
  assign dbg_count    = count;

  // Accepted non-r0 writes, ordered oldest first into two slots.
  always_comb begin
    mem_keep = bus.memValid & bus.memReady & (bus.memA != 5'd0);
    alu_keep = bus.aluValid & bus.aluReady & (bus.aluA != 5'd0);
    s0_v = mem_keep | alu_keep;
    s1_v = mem_keep & alu_keep;
    s0_a = mem_keep ? bus.memA : bus.aluA;
    s0_d = mem_keep ? bus.memD : bus.aluD;
    s1_a = bus.aluA;
    s1_d = bus.aluD;
  end

  // Decide pop/bypass and which slots are written into the buffer.
  always_comb begin
    pop    = (count != '0);
    bypass = !pop && s0_v;
    e0_v = 1'b0;
    e0_a = s0_a;
    e0_d = s0_d;
    e1_v = 1'b0;
    e1_a = s1_a;
    e1_d = s1_d;
    if (pop) begin
      e0_v = s0_v;
      e1_v = s1_v;
    end else begin
      // Oldest new write bypasses; only the younger one is stored.
      e0_v = s1_v;
      e0_a = s1_a;
      e0_d = s1_d;
    end
    pushes = {1'b0, e0_v} + {1'b0, e1_v};
  end

  // Entry storage; validity is tracked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (e0_v) begin
      addr_q[wr_ptr] <= e0_a;
      data_q[wr_ptr] <= e0_d;
    end
    if (e1_v) begin
      addr_q[wr_ptr + PW'(1)] <= e1_a;
      data_q[wr_ptr + PW'(1)] <= e1_d;
    end
  end

  // Pointers, occupancy and the register-file write port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      bus.wA   <= 5'd0;
      bus.wD   <= 32'd0;
      bus.wrEn <= 1'b0;
    end else begin
      count  <= count + CW'(pushes) - CW'(pop);
      wr_ptr <= wr_ptr + PW'(pushes);
      if (pop) begin
        bus.wA   <= addr_q[rd_ptr];
        bus.wD   <= data_q[rd_ptr];
        bus.wrEn <= 1'b1;
        rd_ptr   <= rd_ptr + PW'(1);
      end else if (bypass) begin
        bus.wA   <= s0_a;
        bus.wD   <= s0_d;
        bus.wrEn <= 1'b1;
      end else begin
        bus.wrEn <= 1'b0;
      end
    end
  end

  // Mark which buffer slots currently hold queued entries.
  always_comb begin
    logic [PW-1:0] off;
    live = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off     = PW'(i) - rd_ptr;
      live[i] = ({1'b0, off} < count);
    end
  end

  // RAW hazard flags: queued entries plus the write on the port this cycle.
  always_comb begin
    bus.pend1 = 1'b0;
    bus.pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (addr_q[i] == bus.rA1)) bus.pend1 = 1'b1;
      if (live[i] && (addr_q[i] == bus.rA2)) bus.pend2 = 1'b1;
    end
    if (bus.wrEn && (bus.wA == bus.rA1)) bus.pend1 = 1'b1;
    if (bus.wrEn && (bus.wA == bus.rA2)) bus.pend2 = 1'b1;
    if (bus.rA1 == 5'd0) bus.pend1 = 1'b0;
    if (bus.rA2 == 5'd0) bus.pend2 = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed cases plus random traffic against a
// list-based reference model; a negedge monitor checks outputs against it.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_count;

  regfile_wb_queue_if bus ();

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_count (dbg_count)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: writes accepted but not yet on the port, in age order.
  logic [36:0] model_l [$];
  // Scoreboard: every non-r0 write accepted, in required retirement order.
  logic [36:0] exp_q [$];
  bit          model_wren = 1'b0;
  logic [4:0]  model_wa   = 5'd0;
  bit          last_mem_acc = 1'b0;
  bit          last_alu_acc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pend(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
    if (model_wren && (model_wa == ra)) return 1'b1;
    foreach (model_l[i]) if (model_l[i][36:32] == ra) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one rising edge using the inputs the bench drove.
  task automatic model_edge();
    int          free;
    logic [36:0] e;
    free = DEPTH - model_l.size();
    last_mem_acc = bus.memValid && (free >= 1);
    last_alu_acc = bus.aluValid && (free >= 2);
    if (last_mem_acc && bus.memA != 5'd0) begin
      model_l.push_back({bus.memA, bus.memD});
      exp_q.push_back({bus.memA, bus.memD});
    end
    if (last_alu_acc && bus.aluA != 5'd0) begin
      model_l.push_back({bus.aluA, bus.aluD});
      exp_q.push_back({bus.aluA, bus.aluD});
    end
    if (model_l.size() > 0) begin
      e = model_l.pop_front();
      model_wren = 1'b1;
      model_wa   = e[36:32];
    end else begin
      model_wren = 1'b0;
    end
  endtask

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_src();
    bus.memValid = 1'b0;
    bus.aluValid = 1'b0;
  endtask

  // Monitor: compares DUT outputs to the model and pops the scoreboard.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst_n) begin
      check("mem_ready", bus.memReady, (DEPTH - model_l.size()) >= 1);
      check("alu_ready", bus.aluReady, (DEPTH - model_l.size()) >= 2);
      check("count", dbg_count, 64'(model_l.size()));
      check("wr_en", bus.wrEn, model_wren);
      check("pend1", bus.pend1, model_pend(bus.rA1));
      check("pend2", bus.pend2, model_pend(bus.rA2));
      if (bus.wrEn) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("w_addr", bus.wA, e[36:32]);
          check("w_data", bus.wD, e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [4:0] fill_a [$];
    rst_n = 1'b0;
    bus.memValid = 1'b0; bus.memA = 5'd0; bus.memD = 32'd0;
    bus.aluValid = 1'b0; bus.aluA = 5'd0; bus.aluD = 32'd0;
    bus.rA1 = 5'd0; bus.rA2 = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wren", bus.wrEn, 0);
    check("rst_wa", bus.wA, 0);
    check("rst_wd", bus.wD, 0);
    rst_n = 1'b1;
    idle(2);

    // Single ALU write to r5.
    bus.aluValid = 1'b1; bus.aluA = 5'd5; bus.aluD = 32'hDEADBEEF;
    step();
    clear_src();
    idle(3);

    // Dual push: mem r3 then ALU r7.
    bus.memValid = 1'b1; bus.memA = 5'd3; bus.memD = 32'h1;
    bus.aluValid = 1'b1; bus.aluA = 5'd7; bus.aluD = 32'h2;
    step();
    clear_src();
    idle(3);

    // Register 0 write is dropped.
    bus.rA1 = 5'd0;
    bus.aluValid = 1'b1; bus.aluA = 5'd0; bus.aluD = 32'hFFFF;
    bus.memValid = 1'b1; bus.memA = 5'd4; bus.memD = 32'h4;
    step();
    clear_src();
    idle(3);

    // Hazard on r9 with rA1=9, rA2=10.
    bus.rA1 = 5'd9; bus.rA2 = 5'd10;
    bus.aluValid = 1'b1; bus.aluA = 5'd9; bus.aluD = 32'h99;
    step();
    clear_src();
    idle(3);

    // Fill with r1..r8 from both sources every cycle.
    for (int a = 1; a <= 8; a++) fill_a.push_back(5'(a));
    last_mem_acc = 1'b0;
    last_alu_acc = 1'b0;
    for (int guard = 0; guard < 60; guard++) begin
      if (!bus.memValid || last_mem_acc) begin
        if (fill_a.size() > 0) begin
          bus.memValid = 1'b1; bus.memA = fill_a.pop_front(); bus.memD = $urandom();
        end else bus.memValid = 1'b0;
      end
      if (!bus.aluValid || last_alu_acc) begin
        if (fill_a.size() > 0) begin
          bus.aluValid = 1'b1; bus.aluA = fill_a.pop_front(); bus.aluD = $urandom();
        end else bus.aluValid = 1'b0;
      end
      if (!bus.memValid && !bus.aluValid) break;
      step();
    end
    check("fill_done", fill_a.size() + 32'(bus.memValid) + 32'(bus.aluValid), 0);
    idle(6);

    // Random traffic honouring the hold-until-accepted rule.
    last_mem_acc = 1'b0;
    last_alu_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.memValid || last_mem_acc) begin
        bus.memValid = ($urandom_range(0, 3) != 0);
        bus.memA = 5'($urandom_range(0, 7));
        bus.memD = $urandom();
      end
      if (!bus.aluValid || last_alu_acc) begin
        bus.aluValid = ($urandom_range(0, 3) != 0);
        bus.aluA = 5'($urandom_range(0, 7));
        bus.aluD = $urandom();
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.rA1 = 5'($urandom_range(0, 7));
        bus.rA2 = 5'($urandom_range(0, 7));
      end
      step();
    end
    clear_src();
    idle(8);

    // Reset while three entries are queued.
    for (int k = 0; k < 3; k++) begin
      bus.memValid = 1'b1; bus.memA = 5'(11 + 2 * k); bus.memD = $urandom();
      bus.aluValid = 1'b1; bus.aluA = 5'(12 + 2 * k); bus.aluD = $urandom();
      step();
    end
    clear_src();
    check("pre_reset_count", dbg_count, 3);
    bus.rA1 = 5'd16; bus.rA2 = 5'd15;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_wren", bus.wrEn, 0);
    check("mid_rst_wa", bus.wA, 0);
    check("mid_rst_wd", bus.wD, 0);
    check("mid_rst_pend1", bus.pend1, 0);
    check("mid_rst_pend2", bus.pend2, 0);
    check("mid_rst_mem_ready", bus.memReady, 1);
    check("mid_rst_alu_ready", bus.aluReady, 1);
    model_l.delete();
    exp_q.delete();
    model_wren = 1'b0;
    last_mem_acc = 1'b0;
    last_alu_acc = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback queue sitting directly upstream of the register-file write decoder. Collects destination writes from the ALU and load/store writeback sources. Up to two writes enter per cycle; they drain in order at one per cycle onto the single register-file write port (`wA`, `wD`, `wrEn`). Also reports per-read-port pending-write status so issue logic can stall on RAW hazards until the write has landed.

## Interface

- `DEPTH`, 4, queue entries; power of two, ≥ 2
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `memValid`  in  1  load/store writeback request
- `memA`  in  5  load/store destination register
- `memD`  in  32  load/store write data
- `memReady`  out  1  queue accepts a mem request this cycle
- `aluValid`  in  1  ALU writeback request
- `aluA`  in  5  ALU destination register
- `aluD`  in  32  ALU write data
- `aluReady`  out  1  queue accepts an ALU request this cycle
- `wA`  out  5  register-file write address (to decoder)
- `wD`  out  32  register-file write data
- `wrEn`  out  1  register-file write enable (to decoder)
- `rA1`, `rA2`  in  5 each  read addresses being issued
- `pend1`, `pend2`  out  1 each  a write to `rA1`/`rA2` is queued or on the port

## Operation

- Storage: circular buffer of `DEPTH` entries {addr, data}, read/write pointers, and `count` (0..`DEPTH`).
- `free = DEPTH - count`, taken from registered state only.
- `memReady = (free >= 1)`. `aluReady = (free >= 2)`. Neither depends on any valid input, so there is no valid→ready combinational path.
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. Sources hold valid, address and data stable until the transfer.
- Ordering: when both sources transfer in the same cycle, the mem entry is older than the ALU entry.
- Register 0 is hardwired zero:
  - A transfer with address 0 completes the handshake normally.
  - It is discarded: never enqueued, never counted, never driven to `wA`.
- Drain: on each edge the output registers load the oldest available entry and set `wrEn=1`. If none is available, `wrEn=0`; `wA`/`wD` hold their last value.
- Bypass: when `count==0`, the oldest entry accepted at that edge goes straight to the output registers. A second accepted entry is enqueued.
- Count update: `count_next = count + pushes - pop`.
  - `pushes` is 0..2 and excludes discarded writes.
  - `pop` is 1 when an entry left the queue for the output registers.
  - A bypassed entry never counts.
- Pending flags, combinational:
  - `pendN = 1` if `rAN != 0` and `rAN` matches any valid queue entry address, or `wrEn && wA == rAN`.
  - The output-register match is included because the register file commits at the end of the `wrEn` cycle.
- Overflow is structurally impossible given the ready rules. The implementation must contain no error path.

## Timing

- Reset (async assert, sync release): `count=0`, pointers 0, `wrEn=0`, `wA=0`, `wD=0`.
  - Hence `memReady=aluReady=1` and `pend1=pend2=0`.
  - All queued data is lost, including during mid-drain.
- Latency: a write accepted at edge N with an empty queue has `wrEn=1` in the cycle following edge N.
- Throughput: one write retired per cycle. Sustained dual push fills the queue at 1 entry/cycle net.
- Full/nearly full:
  - At `free==1`, only mem is accepted.
  - At `free==0`, neither is accepted; ready recovers the cycle after a pop.
- Simultaneous push and pop at `count==DEPTH-1` with a single push: `count` is unchanged.
- Pointer wrap: modulo `DEPTH`, no bubble at the wrap.
- `pendN` clears in the cycle after the last matching `wrEn` cycle.

## Test plan

- Single write: ALU r5=0xDEADBEEF at edge 1, empty queue. Required: `wA=5`, `wD=0xDEADBEEF`, `wrEn=1` for exactly one cycle after edge 1, then `wrEn=0`.
- Dual push: same edge, mem r3=0x1 and ALU r7=0x2. Required: r3 appears on the port, then r7 on the next cycle, back-to-back; `count` peaks at 1.
- Fill: both sources valid every cycle with distinct addresses r1..r8, `DEPTH=4`.
  - `aluReady` drops when `free<2`; `memReady` drops at `free==0`.
  - All accepted writes emerge exactly once, in order, with no gaps.
- Register 0: ALU r0=0xFFFF and mem r4=0x4 on the same edge. Only r4 appears; `pend1` stays 0 with `rA1=0` throughout.
- Hazard: enqueue r9 with `rA1=9` held.
  - `pend1=1` from the cycle after acceptance through the `wrEn` cycle for r9.
  - `pend1=0` the following cycle.
  - `rA2=10` gives `pend2=0` throughout.
- Reset mid-drain: 3 entries queued, `rst_n` low between edges. Immediately `wrEn=0`, `wA=0`, `wD=0`, `pend*=0`. After release, both readies are 1 and no stale entry appears.
